traffic_signal_monitor: RTL and testbench

- Passive conflict monitor that watches the signal-head outputs of the highway/country traffic controller (hwy, cntry) and the country-road sensor X.
- Checks each cycle for unsafe or illegal light behaviour. Latches the first fault with a code and counts all violations.
- Its fault output drives the flash-red override and the maintenance log.

---
 rtl/traffic_signal_monitor.sv | 128 ++++++++++++
 tb/tb_traffic_signal_monitor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_signal_monitor.sv
// Passive conflict monitor for the highway/country signal heads.
// Flags unsafe or illegal light behaviour, latches the first fault code and counts violating cycles.
module traffic_signal_monitor #(
    parameter int MIN_YELLOW = 3,
    parameter int MIN_ALLRED = 2,
    parameter int MAX_WAIT   = 64,
    parameter int CW         = 8
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [1:0] hwy,
    input  logic [1:0] cntry,
    input  logic       X,
    input  logic       ack,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] viol_count
);

    localparam logic [1:0] RED = 2'd0;
    localparam logic [1:0] YEL = 2'd1;
    localparam logic [1:0] GRN = 2'd2;
    localparam logic [1:0] BAD = 2'd3;

    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] MIN_YEL_C = CW'(MIN_YELLOW);
    localparam logic [CW-1:0] MIN_AR_C  = CW'(MIN_ALLRED);
    localparam logic [CW-1:0] WAIT_LIM  = CW'(MAX_WAIT);

    logic [1:0]    prev_hwy_q, prev_hwy_d;
    logic [1:0]    prev_cntry_q, prev_cntry_d;
    logic [CW-1:0] yel_hwy_q, yel_hwy_d;
    logic [CW-1:0] yel_cntry_q, yel_cntry_d;
    logic [CW-1:0] allred_q, allred_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          primed_q, primed_d;
    logic          fault_q, fault_d;
    logic [2:0]    code_q, code_d;
    logic [7:0]    viol_q, viol_d;

    logic [6:1]    viol;
    logic [2:0]    win_code;
    logic          wait_inc;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + ONE;
    endfunction

    // Only G->R, Y->G and R->Y are transition faults; illegal encodings are reported by their own check.
    function automatic logic bad_step(input logic [1:0] p, input logic [1:0] n);
        return (p == GRN && n == RED) || (p == YEL && n == GRN) || (p == RED && n == YEL);
    endfunction

    always_comb begin
        prev_hwy_d   = hwy;
        prev_cntry_d = cntry;
        primed_d     = 1'b1;
        yel_hwy_d    = (hwy == YEL) ? sat_inc(yel_hwy_q) : '0;
        yel_cntry_d  = (cntry == YEL) ? sat_inc(yel_cntry_q) : '0;
        allred_d     = (hwy == RED && cntry == RED) ? sat_inc(allred_q) : '0;
        wait_inc     = X && (cntry != GRN);
        wait_d       = '0;
        if (wait_inc) begin
            wait_d = (wait_q < WAIT_LIM) ? sat_inc(wait_q) : wait_q;
        end

        viol    = '0;
        viol[1] = (hwy != RED) && (cntry != RED);
        viol[2] = (hwy == BAD) || (cntry == BAD);
        viol[3] = primed_q && (bad_step(prev_hwy_q, hwy) || bad_step(prev_cntry_q, cntry));
        viol[4] = (prev_hwy_q == YEL && hwy == RED && yel_hwy_q < MIN_YEL_C) ||
                  (prev_cntry_q == YEL && cntry == RED && yel_cntry_q < MIN_YEL_C);
        viol[5] = primed_q && (allred_q < MIN_AR_C) &&
                  ((prev_hwy_q == RED && hwy == GRN) || (prev_cntry_q == RED && cntry == GRN));
        viol[6] = wait_inc && (wait_q < WAIT_LIM) && (wait_q + ONE == WAIT_LIM);

        win_code = 3'd0;
        for (int k = 6; k >= 1; k--) begin
            if (viol[k]) win_code = 3'(k);
        end

        fault_d = fault_q;
        code_d  = code_q;
        viol_d  = viol_q;
        if (|viol) begin
            if (!fault_q || ack) begin
                fault_d = 1'b1;
                code_d  = win_code;
            end
            if (viol_q != 8'hFF) viol_d = viol_q + 8'd1;
        end else if (ack) begin
            fault_d = 1'b0;
            code_d  = 3'd0;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            prev_hwy_q   <= RED;
            prev_cntry_q <= RED;
            yel_hwy_q    <= '0;
            yel_cntry_q  <= '0;
            allred_q     <= '0;
            wait_q       <= '0;
            primed_q     <= 1'b0;
            fault_q      <= 1'b0;
            code_q       <= 3'd0;
            viol_q       <= 8'd0;
        end else begin
            prev_hwy_q   <= prev_hwy_d;
            prev_cntry_q <= prev_cntry_d;
            yel_hwy_q    <= yel_hwy_d;
            yel_cntry_q  <= yel_cntry_d;
            allred_q     <= allred_d;
            wait_q       <= wait_d;
            primed_q     <= primed_d;
            fault_q      <= fault_d;
            code_q       <= code_d;
            viol_q       <= viol_d;
        end
    end

    assign fault      = fault_q;
    assign fault_code = code_q;
    assign viol_count = viol_q;

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Bench for traffic_signal_monitor: directed scenarios plus randomized light sequences
// compared against a history-based reference model.
module tb_traffic_signal_monitor;

    localparam int MIN_YELLOW = 3;
    localparam int MIN_ALLRED = 2;
    localparam int MAX_WAIT   = 64;

    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] hwy   = 2'd0;
    logic [1:0] cntry = 2'd0;
    logic       X     = 1'b0;
    logic       ack   = 1'b0;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] viol_count;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state: full sample history since the last reset
    int q_h[$];
    int q_c[$];
    int q_x[$];
    int m_fault = 0;
    int m_code  = 0;
    int m_count = 0;

    traffic_signal_monitor #(
        .MIN_YELLOW(MIN_YELLOW), .MIN_ALLRED(MIN_ALLRED), .MAX_WAIT(MAX_WAIT), .CW(8)
    ) dut (
        .clock(clock), .clear(clear), .hwy(hwy), .cntry(cntry), .X(X), .ack(ack),
        .fault(fault), .fault_code(fault_code), .viol_count(viol_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        else n_pass++;
    endtask

    function automatic bit bad_trans(input int p, input int n);
        bit legal;
        legal = (p == n) || (p == 2 && n == 1) || (p == 1 && n == 0) || (p == 0 && n == 2);
        return !legal && p != 3 && n != 3;
    endfunction

    task automatic model_reset();
        q_h.delete(); q_c.delete(); q_x.delete();
        m_fault = 0; m_code = 0; m_count = 0;
    endtask

    task automatic model_step(input int h, input int c, input int x, input int a);
        int ph, pc, yh, yc, ar, wr, code;
        bit primed;
        bit v[7];
        primed = q_h.size() > 0;
        ph = primed ? q_h[q_h.size()-1] : 0;
        pc = primed ? q_c[q_c.size()-1] : 0;
        yh = 0; yc = 0; ar = 0; wr = 0;
        for (int i = q_h.size()-1; i >= 0 && yh < 255 && q_h[i] == 1; i--) yh++;
        for (int i = q_c.size()-1; i >= 0 && yc < 255 && q_c[i] == 1; i--) yc++;
        for (int i = q_h.size()-1; i >= 0 && ar < 255 && q_h[i] == 0 && q_c[i] == 0; i--) ar++;
        for (int i = q_h.size()-1; i >= 0 && wr < MAX_WAIT && q_x[i] == 1 && q_c[i] != 2; i--) wr++;
        for (int k = 0; k < 7; k++) v[k] = 1'b0;
        v[1] = h != 0 && c != 0;
        v[2] = h == 3 || c == 3;
        v[3] = primed && (bad_trans(ph, h) || bad_trans(pc, c));
        v[4] = (ph == 1 && h == 0 && yh < MIN_YELLOW) || (pc == 1 && c == 0 && yc < MIN_YELLOW);
        v[5] = primed && ar < MIN_ALLRED && ((ph == 0 && h == 2) || (pc == 0 && c == 2));
        v[6] = x == 1 && c != 2 && wr == MAX_WAIT - 1;
        code = 0;
        for (int k = 6; k >= 1; k--) if (v[k]) code = k;
        if (code != 0) begin
            if (m_fault == 0 || a == 1) begin
                m_fault = 1;
                m_code  = code;
            end
            if (m_count < 255) m_count++;
        end else if (a == 1) begin
            m_fault = 0;
            m_code  = 0;
        end
        q_h.push_back(h); q_c.push_back(c); q_x.push_back(x);
    endtask

    // called just after a rising edge; leaves clear released just after the next one
    task automatic do_reset();
        clear = 1'b0;
        #2;
        model_reset();
        chk("rst_fault", 32'(fault), 0);
        chk("rst_code", 32'(fault_code), 0);
        chk("rst_count", 32'(viol_count), 0);
        @(posedge clock);
        #1;
        clear = 1'b1;
    endtask

    task automatic step(input int h, input int c, input int x, input int a);
        hwy = 2'(h); cntry = 2'(c); X = x[0]; ack = a[0];
        @(posedge clock);
        #1;
        model_step(h, c, x, a);
        chk("fault", 32'(fault), m_fault);
        chk("code", 32'(fault_code), m_code);
        chk("count", 32'(viol_count), m_count);
    endtask

    function automatic int next_light(input int cur);
        int r;
        r = int'($urandom_range(99));
        if (r < 70) return cur;
        if (r < 95) return (cur == 0) ? 2 : (cur == 2) ? 1 : 0;
        return int'($urandom_range(3));
    endfunction

    initial begin
        int rh, rc, rx;
        do_reset();

        // legal cycle through both roads
        for (int i = 0; i < 5; i++) step(2, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 2, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0);
        step(2, 0, 0, 0);
        chk("legal_fault", 32'(fault), 0);
        chk("legal_count", 32'(viol_count), 0);

        // conflict, then further violations keep the first code
        step(2, 2, 0, 0);
        chk("conflict_code", 32'(fault_code), 1);
        chk("conflict_count", 32'(viol_count), 1);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("hold_code", 32'(fault_code), 1);
        chk("hold_count", 32'(viol_count), 3);

        // ack clean, then short yellow
        step(0, 0, 0, 1);
        chk("ack_fault", 32'(fault), 0);
        chk("ack_code", 32'(fault_code), 0);
        step(2, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("short_yel", 32'(fault_code), 4);

        // direct G->R
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(2, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("g_to_r", 32'(fault_code), 3);
        step(0, 0, 0, 1);

        // short clearance, then proper clearance
        step(2, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 2, 0, 0);
        chk("short_clr", 32'(fault_code), 5);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 2, 0, 0);
        chk("good_clr_fault", 32'(fault), 0);

        // starvation
        do_reset();
        for (int i = 0; i < 63; i++) step(2, 0, 1, 0);
        chk("starve_pre", 32'(fault), 0);
        step(2, 0, 1, 0);
        chk("starve_code", 32'(fault_code), 6);
        chk("starve_count", 32'(viol_count), 1);
        for (int i = 0; i < 10; i++) step(2, 0, 1, 0);
        chk("starve_once", 32'(viol_count), 1);
        step(2, 0, 0, 0);

        // illegal encoding, then ack alongside a new conflict
        do_reset();
        step(3, 0, 0, 0);
        chk("illegal_code", 32'(fault_code), 2);
        step(2, 2, 0, 1);
        chk("ack_conf_fault", 32'(fault), 1);
        chk("ack_conf_code", 32'(fault_code), 1);

        // clear mid-yellow; first post-reset transition unchecked
        do_reset();
        step(2, 0, 0, 0);
        step(2, 2, 0, 0);
        step(1, 0, 0, 0);
        do_reset();
        step(1, 0, 0, 0);
        chk("unprimed_fault", 32'(fault), 0);
        step(0, 0, 0, 0);

        // randomized sequences
        rh = 0; rc = 0; rx = 0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(199) == 0) do_reset();
            rh = next_light(rh);
            rc = next_light(rc);
            if ($urandom_range(9) == 0) rx = 1 - rx;
            step(rh, rc, rx, ($urandom_range(9) == 0) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
